// File: rtl/uart_rx_param_if.sv
// Receive-side FIFO write handshake plus the per-frame status pulses.
// The receiver drives everything except the full flag.
interface uart_rx_param_if #(
  parameter int unsigned P_DATA_BITS = 8
);
  logic [P_DATA_BITS-1:0] rx_fifo_data;
  logic                   rx_fifo_wr_en;
  logic                   rx_fifo_full;
  logic                   rx_parity_err;
  logic                   rx_frame_err;
  logic                   rx_overrun;
  logic                   rx_break;

  modport master (
    output rx_fifo_data,
    output rx_fifo_wr_en,
    output rx_parity_err,
    output rx_frame_err,
    output rx_overrun,
    output rx_break,
    input  rx_fifo_full
  );

  modport slave (
    input  rx_fifo_data,
    input  rx_fifo_wr_en,
    input  rx_parity_err,
    input  rx_frame_err,
    input  rx_overrun,
    input  rx_break,
    output rx_fifo_full
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-vote sampling, false-start rejection,
// parity/framing/overrun/break reporting, one FIFO write per good frame.
module uart_rx_param #(
  parameter int unsigned P_CLK_FREQ_HZ = 100000000,
  parameter int unsigned P_BAUD_RATE   = 9600,
  parameter int unsigned P_DATA_BITS   = 8,
  parameter int unsigned P_PARITY      = 0,
  parameter int unsigned P_STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  uart_rx_param_if.master       rx_fifo
);

  localparam int unsigned N        = P_CLK_FREQ_HZ / P_BAUD_RATE;
  localparam int unsigned CntW     = $clog2(N + 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(N / 2);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);
  localparam logic [3:0] LastData  = 4'(P_DATA_BITS - 1);
  localparam logic [3:0] LastStop  = 4'(P_STOP_BITS - 1);
  localparam logic       OddParity = (P_PARITY == 2);
  localparam logic       HasParity = (P_PARITY != 0);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  state_e                 state_q;
  logic [1:0]             sync_q;
  logic [2:0]             hist_q;
  logic [CntW-1:0]        latch_cnt_q;
  logic [3:0]             bit_cnt_q;
  logic [P_DATA_BITS-1:0] shift_q;
  logic                   par_err_q;
  logic                   frm_err_q;
  logic                   zero_q;

  logic rx_s;
  logic vote;
  logic bit_tick;
  logic stop_bad;
  logic all_zero;

  assign rx_s     = sync_q[1];
  assign vote     = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign bit_tick = (latch_cnt_q == LastCnt);
  // Final verdict folds in the stop sample being taken this cycle.
  assign stop_bad = frm_err_q | ~vote;
  assign all_zero = zero_q & ~vote;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q                <= StIdle;
      sync_q                 <= 2'b11;
      hist_q                 <= 3'b111;
      latch_cnt_q            <= '0;
      bit_cnt_q              <= '0;
      shift_q                <= '0;
      par_err_q              <= 1'b0;
      frm_err_q              <= 1'b0;
      zero_q                 <= 1'b0;
      rx_fifo.rx_fifo_data   <= '0;
      rx_fifo.rx_fifo_wr_en  <= 1'b0;
      rx_fifo.rx_parity_err  <= 1'b0;
      rx_fifo.rx_frame_err   <= 1'b0;
      rx_fifo.rx_overrun     <= 1'b0;
      rx_fifo.rx_break       <= 1'b0;
    end else begin
      sync_q                 <= {sync_q[0], rx};
      hist_q                 <= {hist_q[1:0], rx_s};
      rx_fifo.rx_fifo_wr_en  <= 1'b0;
      rx_fifo.rx_parity_err  <= 1'b0;
      rx_fifo.rx_frame_err   <= 1'b0;
      rx_fifo.rx_overrun     <= 1'b0;
      rx_fifo.rx_break       <= 1'b0;

      unique case (state_q)
        StIdle: begin
          latch_cnt_q <= '0;
          bit_cnt_q   <= '0;
          if (!rx_s && hist_q[0]) begin
            state_q   <= StStart;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            zero_q    <= 1'b1;
          end
        end

        StStart: begin
          if (latch_cnt_q == HalfCnt) begin
            latch_cnt_q <= '0;
            // A start bit that has gone high again by mid-bit was a glitch.
            state_q     <= vote ? StIdle : StData;
          end else begin
            latch_cnt_q <= latch_cnt_q + 1'b1;
          end
        end

        StData: begin
          if (bit_tick) begin
            latch_cnt_q <= '0;
            shift_q     <= {vote, shift_q[P_DATA_BITS-1:1]};
            zero_q      <= zero_q & ~vote;
            if (bit_cnt_q == LastData) begin
              bit_cnt_q <= '0;
              state_q   <= HasParity ? StParity : StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end else begin
            latch_cnt_q <= latch_cnt_q + 1'b1;
          end
        end

        StParity: begin
          if (bit_tick) begin
            latch_cnt_q <= '0;
            zero_q      <= zero_q & ~vote;
            par_err_q   <= ((^shift_q) ^ vote) != OddParity;
            state_q     <= StStop;
          end else begin
            latch_cnt_q <= latch_cnt_q + 1'b1;
          end
        end

        StStop: begin
          if (bit_tick) begin
            latch_cnt_q <= '0;
            if (bit_cnt_q == LastStop) begin
              bit_cnt_q <= '0;
              if (all_zero) begin
                rx_fifo.rx_break <= 1'b1;
                state_q          <= StBreak;
              end else if (stop_bad) begin
                rx_fifo.rx_frame_err <= 1'b1;
                state_q              <= StIdle;
              end else if (rx_fifo.rx_fifo_full) begin
                rx_fifo.rx_overrun <= 1'b1;
                state_q            <= StIdle;
              end else begin
                rx_fifo.rx_fifo_wr_en <= 1'b1;
                rx_fifo.rx_fifo_data  <= shift_q;
                rx_fifo.rx_parity_err <= par_err_q;
                state_q               <= StIdle;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              frm_err_q <= frm_err_q | ~vote;
              zero_q    <= zero_q & ~vote;
            end
          end else begin
            latch_cnt_q <= latch_cnt_q + 1'b1;
          end
        end

        StBreak: begin
          latch_cnt_q <= '0;
          bit_cnt_q   <= '0;
          if (rx_s) begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: 8N1, 8E1 and 7N2 instances at N=10, with a
// per-instance queue of expected output events.
module tb_uart_rx_param;

  localparam int unsigned BitCycles = 10;

  logic clk;
  logic rst_n;
  logic rx_a;
  logic rx_b;
  logic rx_c;

  int n_checks = 0;
  int n_pass   = 0;

  // Event code: {wr_en, parity_err, frame_err, overrun, break, data[8:0]}
  logic [13:0] q_a[$];
  logic [13:0] q_b[$];
  logic [13:0] q_c[$];
  logic [13:0] obs_a;
  logic [13:0] obs_b;
  logic [13:0] obs_c;

  uart_rx_param_if #(.P_DATA_BITS(8)) fifo_a ();
  uart_rx_param_if #(.P_DATA_BITS(8)) fifo_b ();
  uart_rx_param_if #(.P_DATA_BITS(7)) fifo_c ();

  uart_rx_param #(
    .P_CLK_FREQ_HZ(1000000), .P_BAUD_RATE(100000), .P_DATA_BITS(8), .P_PARITY(0),
    .P_STOP_BITS(1)
  ) u_dut_8n1 (.clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_fifo(fifo_a));

  uart_rx_param #(
    .P_CLK_FREQ_HZ(1000000), .P_BAUD_RATE(100000), .P_DATA_BITS(8), .P_PARITY(1),
    .P_STOP_BITS(1)
  ) u_dut_8e1 (.clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_fifo(fifo_b));

  uart_rx_param #(
    .P_CLK_FREQ_HZ(1000000), .P_BAUD_RATE(100000), .P_DATA_BITS(7), .P_PARITY(0),
    .P_STOP_BITS(2)
  ) u_dut_7n2 (.clk(clk), .rst_n(rst_n), .rx(rx_c), .rx_fifo(fifo_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic logic [13:0] ev(input logic wr, input logic perr, input logic ferr,
                                     input logic ovr, input logic brk, input logic [8:0] data);
    return {wr, perr, ferr, ovr, brk, data};
  endfunction

  task automatic expect_ev(input int ch, input logic [13:0] code);
    case (ch)
      0:       q_a.push_back(code);
      1:       q_b.push_back(code);
      default: q_c.push_back(code);
    endcase
  endtask

  task automatic score(input int ch, input logic [13:0] obs);
    logic [13:0] want;
    bit have;
    have = 1'b0;
    want = '0;
    case (ch)
      0: if (q_a.size() > 0) begin have = 1'b1; want = q_a.pop_front(); end
      1: if (q_b.size() > 0) begin have = 1'b1; want = q_b.pop_front(); end
      default: if (q_c.size() > 0) begin have = 1'b1; want = q_c.pop_front(); end
    endcase
    if (have) check_eq($sformatf("event_ch%0d", ch), 32'(obs), 32'(want));
    else check_eq($sformatf("unexpected_event_ch%0d", ch), 32'(obs), 32'h0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      obs_a = ev(fifo_a.rx_fifo_wr_en, fifo_a.rx_parity_err, fifo_a.rx_frame_err,
                 fifo_a.rx_overrun, fifo_a.rx_break,
                 fifo_a.rx_fifo_wr_en ? {1'b0, fifo_a.rx_fifo_data} : 9'd0);
      obs_b = ev(fifo_b.rx_fifo_wr_en, fifo_b.rx_parity_err, fifo_b.rx_frame_err,
                 fifo_b.rx_overrun, fifo_b.rx_break,
                 fifo_b.rx_fifo_wr_en ? {1'b0, fifo_b.rx_fifo_data} : 9'd0);
      obs_c = ev(fifo_c.rx_fifo_wr_en, fifo_c.rx_parity_err, fifo_c.rx_frame_err,
                 fifo_c.rx_overrun, fifo_c.rx_break,
                 fifo_c.rx_fifo_wr_en ? {2'b0, fifo_c.rx_fifo_data} : 9'd0);
      if (obs_a != '0) score(0, obs_a);
      if (obs_b != '0) score(1, obs_b);
      if (obs_c != '0) score(2, obs_c);
    end
  end

  task automatic drive_rx(input int ch, input logic v);
    case (ch)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic send_bits(input int ch, input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      drive_rx(ch, bits[i]);
      repeat (BitCycles) @(negedge clk);
    end
  endtask

  task automatic idle_bits(input int ch, input int nbits);
    drive_rx(ch, 1'b1);
    repeat (nbits * BitCycles) @(negedge clk);
  endtask

  // par: 0 none, 1 even, 2 odd; stops LSB is the first stop bit on the line.
  task automatic send_frame(input int ch, input logic [8:0] data, input int nd, input int par,
                            input bit flip_par, input logic [1:0] stops, input int ns);
    logic [15:0] bits;
    logic p;
    int idx;
    bits = '0;
    p    = 1'b0;
    idx  = 1;
    for (int i = 0; i < nd; i++) begin
      bits[idx] = data[i];
      p ^= data[i];
      idx++;
    end
    if (par != 0) begin
      bits[idx] = ((par == 2) ? ~p : p) ^ flip_par;
      idx++;
    end
    for (int i = 0; i < ns; i++) begin
      bits[idx] = stops[i];
      idx++;
    end
    send_bits(ch, bits, idx);
  endtask

  logic [15:0] partial;

  initial begin
    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    rx_c  = 1'b1;
    fifo_a.rx_fifo_full = 1'b0;
    fifo_b.rx_fifo_full = 1'b0;
    fifo_c.rx_fifo_full = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("reset_wr_en", 32'(fifo_a.rx_fifo_wr_en), 32'h0);
    check_eq("reset_data", 32'(fifo_a.rx_fifo_data), 32'h0);
    check_eq("reset_frame_err", 32'(fifo_a.rx_frame_err), 32'h0);
    check_eq("reset_break", 32'(fifo_a.rx_break), 32'h0);
    check_eq("reset_overrun", 32'(fifo_a.rx_overrun), 32'h0);
    check_eq("reset_parity_err", 32'(fifo_a.rx_parity_err), 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // 8N1 back-to-back with zero idle
    expect_ev(0, ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h055));
    expect_ev(0, ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0A3));
    send_frame(0, 9'h055, 8, 0, 1'b0, 2'b11, 1);
    send_frame(0, 9'h0A3, 8, 0, 1'b0, 2'b11, 1);
    idle_bits(0, 2);

    // FIFO full: dropped character, data output holds
    fifo_a.rx_fifo_full = 1'b1;
    expect_ev(0, ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000));
    send_frame(0, 9'h03C, 8, 0, 1'b0, 2'b11, 1);
    idle_bits(0, 2);
    fifo_a.rx_fifo_full = 1'b0;
    check_eq("overrun_data_hold", 32'(fifo_a.rx_fifo_data), 32'hA3);

    // Break: line low for a full frame plus 3 bit periods
    expect_ev(0, ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h000));
    send_bits(0, 16'h0000, 13);
    idle_bits(0, 2);
    expect_ev(0, ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h012));
    send_frame(0, 9'h012, 8, 0, 1'b0, 2'b11, 1);
    idle_bits(0, 2);

    // 3-cycle glitch must not start a frame
    drive_rx(0, 1'b0);
    repeat (3) @(negedge clk);
    idle_bits(0, 15);

    // Reset mid-frame: start bit plus three data bits of 0x99, then abandon
    partial = 16'h0132;
    send_bits(0, partial, 4);
    rst_n = 1'b0;
    drive_rx(0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midreset_wr_en", 32'(fifo_a.rx_fifo_wr_en), 32'h0);
    check_eq("midreset_data", 32'(fifo_a.rx_fifo_data), 32'h0);
    idle_bits(0, 3);
    expect_ev(0, ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h099));
    send_frame(0, 9'h099, 8, 0, 1'b0, 2'b11, 1);
    idle_bits(0, 2);

    // 8E1: bad parity still writes, with parity_err; then good parity
    expect_ev(1, ev(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h007));
    send_frame(1, 9'h007, 8, 1, 1'b1, 2'b11, 1);
    idle_bits(1, 2);
    expect_ev(1, ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h007));
    send_frame(1, 9'h007, 8, 1, 1'b0, 2'b11, 1);
    idle_bits(1, 2);

    // 7N2: second stop low is a framing error; both high is good
    expect_ev(2, ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000));
    send_frame(2, 9'h041, 7, 0, 1'b0, 2'b01, 2);
    idle_bits(2, 2);
    expect_ev(2, ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h041));
    send_frame(2, 9'h041, 7, 0, 1'b0, 2'b11, 2);
    idle_bits(2, 3);

    check_eq("pending_ch0", 32'(q_a.size()), 32'h0);
    check_eq("pending_ch1", 32'(q_b.size()), 32'h0);
    check_eq("pending_ch2", 32'(q_c.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
